// File: rtl/multi_debouncer.sv
// ============================================================================
// multi_debouncer
//
// Purpose:
//   Synchronises and debounces CHANNELS raw button/switch inputs. Each channel
//   provides a debounced level or latched toggle output, one-cycle press and
//   release pulses, and long-press detection. Intended to sit between board
//   I/O pins and the CPU control/step logic in place of per-button debouncers.
//
// Parameters:
//   CHANNELS        number of independent channels (>= 1)
//   CNT_WIDTH       width of each debounce counter
//   DEBOUNCE_LIMIT  stable synchronised samples needed to accept a change
//                   (0 accepts on the edge after the sample register updates)
//   LONG_WIDTH      width of each hold counter
//   LONG_LIMIT      cycles the clean level must stay high for a long press (>= 1)
//
// Ports:
//   i_clk          system clock, all state on posedge
//   i_rst          asynchronous active-high reset, clears every flop
//   i_btn_in       raw asynchronous button inputs
//   i_toggle_en    per-channel mode: 0 = level, 1 = toggle/latch
//   o_btn_out      debounced level or latched toggle state per channel
//   o_rise_pulse   one-cycle pulse on an accepted press
//   o_fall_pulse   one-cycle pulse on an accepted release
//   o_long_pulse   one-cycle pulse when a hold reaches LONG_LIMIT
//   o_long_held    high while the hold counter sits at LONG_LIMIT
//   o_any_change   OR of every rise and fall pulse
// ============================================================================
module multi_debouncer #(
    parameter int                    CHANNELS       = 4,
    parameter int                    CNT_WIDTH      = 20,
    parameter logic [CNT_WIDTH-1:0]  DEBOUNCE_LIMIT = 20'hFFFFF,
    parameter int                    LONG_WIDTH     = 24,
    parameter logic [LONG_WIDTH-1:0] LONG_LIMIT     = 24'hFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHANNELS-1:0] i_btn_in,
    input  logic [CHANNELS-1:0] i_toggle_en,
    output logic [CHANNELS-1:0] o_btn_out,
    output logic [CHANNELS-1:0] o_rise_pulse,
    output logic [CHANNELS-1:0] o_fall_pulse,
    output logic [CHANNELS-1:0] o_long_pulse,
    output logic [CHANNELS-1:0] o_long_held,
    output logic                o_any_change
);

    // The long pulse is raised on the edge where the hold counter moves from
    // LONG_LIMIT-1 to LONG_LIMIT, so compare against the value one below.
    localparam logic [LONG_WIDTH-1:0] LONG_PRE = LONG_LIMIT - 1'b1;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic                  r_sync1;
        logic                  r_sync2;
        logic                  r_prev;
        logic                  r_clean;
        logic                  r_rise;
        logic                  r_fall;
        logic                  r_toggle;
        logic                  r_long;
        logic [CNT_WIDTH-1:0]  r_cnt;
        logic [LONG_WIDTH-1:0] r_hold;
        logic                  w_stable;
        logic                  w_accept;
        logic                  w_clean_next;

        // A change is accepted once the synchronised sample has matched the
        // remembered sample for DEBOUNCE_LIMIT counts and still differs from
        // the clean level. w_clean_next is the clean level after this edge and
        // lets the hold counter react on the same edge as the release.
        assign w_stable     = (r_sync2 == r_prev);
        assign w_accept     = w_stable && (r_cnt == DEBOUNCE_LIMIT) && (r_clean != r_prev);
        assign w_clean_next = w_accept ? r_prev : r_clean;

        // Two-flop synchroniser for the raw, asynchronous pin.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= i_btn_in[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce core: any bounce restarts the stability count; the count
        // saturates at the limit so a long-stable input never wraps around.
        // Edge pulses and the toggle latch update on the accepting edge.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_prev   <= 1'b0;
                r_cnt    <= '0;
                r_clean  <= 1'b0;
                r_rise   <= 1'b0;
                r_fall   <= 1'b0;
                r_toggle <= 1'b0;
            end else begin
                if (!w_stable) begin
                    r_prev <= r_sync2;
                    r_cnt  <= '0;
                end else if (r_cnt < DEBOUNCE_LIMIT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_clean  <= w_clean_next;
                r_rise   <= w_accept && r_prev;
                r_fall   <= w_accept && !r_prev;
                r_toggle <= r_toggle ^ (w_accept && r_prev);
            end
        end

        // Hold counter: counts only while the clean level was already high,
        // so the press edge itself is not counted, and clears on the very
        // edge a release is accepted so long_held drops with fall_pulse.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                if (!w_clean_next) begin
                    r_hold <= '0;
                end else if (r_clean && (r_hold < LONG_LIMIT)) begin
                    r_hold <= r_hold + 1'b1;
                end
                r_long <= w_clean_next && r_clean && (r_hold == LONG_PRE);
            end
        end

        assign o_btn_out[gi]    = i_toggle_en[gi] ? r_toggle : r_clean;
        assign o_rise_pulse[gi] = r_rise;
        assign o_fall_pulse[gi] = r_fall;
        assign o_long_pulse[gi] = r_long;
        assign o_long_held[gi]  = (r_hold == LONG_LIMIT);
    end

    assign o_any_change = |{o_rise_pulse, o_fall_pulse};

endmodule

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// tb_multi_debouncer
//
// Two-channel bench with DEBOUNCE_LIMIT=4 and LONG_LIMIT=10. A change driven
// just after a falling edge is first sampled on the next rising edge E and is
// expected on the clean level at E+7, i.e. eight counted edges after the drive
// point. Every expected pulse event is queued by the stimulus; a monitor pops
// and compares whenever the design raises any rise/fall/long pulse.
// ============================================================================
module tb_multi_debouncer;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lng;
        logic [1:0] out;
        logic [1:0] held;
    } event_t;

    logic       clk;
    logic       rst;
    logic [1:0] btnIn;
    logic [1:0] toggleEn;
    logic [1:0] btnOut;
    logic [1:0] risePulse;
    logic [1:0] fallPulse;
    logic [1:0] longPulse;
    logic [1:0] longHeld;
    logic       anyChange;

    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    event_t scoreboard[$];

    multi_debouncer #(
        .CHANNELS      (2),
        .CNT_WIDTH     (20),
        .DEBOUNCE_LIMIT(20'd4),
        .LONG_WIDTH    (24),
        .LONG_LIMIT    (24'd10)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_in    (btnIn),
        .i_toggle_en (toggleEn),
        .o_btn_out   (btnOut),
        .o_rise_pulse(risePulse),
        .o_fall_pulse(fallPulse),
        .o_long_pulse(longPulse),
        .o_long_held (longHeld),
        .o_any_change(anyChange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic pushExpect(input string name, input int c,
                              input logic [1:0] r, input logic [1:0] f,
                              input logic [1:0] l, input logic [1:0] o,
                              input logic [1:0] h);
        event_t e;
        e.name = name;
        e.cyc  = c;
        e.rise = r;
        e.fall = f;
        e.lng  = l;
        e.out  = o;
        e.held = h;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] v, output int t);
        btnIn = v;
        t     = cyc;
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Direct check taken at a quiet moment: no pulse may be active.
    task automatic checkOutput(input string name, input logic [1:0] expOut,
                               input logic [1:0] expHeld);
        vectors++;
        if (btnOut !== expOut || longHeld !== expHeld || risePulse !== 2'b00 ||
            fallPulse !== 2'b00 || longPulse !== 2'b00 || anyChange !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%b held=%b rise=%b fall=%b long=%b any=%b, want out=%b held=%b and no pulses",
                     name, btnOut, longHeld, risePulse, fallPulse, longPulse, anyChange,
                     expOut, expHeld);
        end
    endtask

    // Monitor: every cycle carrying a pulse must match the head of the queue.
    initial begin : monitor
        event_t e;
        forever begin
            @(posedge clk);
            #1;
            if ((risePulse | fallPulse | longPulse) != 2'b00) begin
                vectors++;
                if (scoreboard.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_event cyc=%0d: got rise=%b fall=%b long=%b, want no event",
                             cyc, risePulse, fallPulse, longPulse);
                end else begin
                    e = scoreboard.pop_front();
                    if (cyc != e.cyc || risePulse !== e.rise || fallPulse !== e.fall ||
                        longPulse !== e.lng || btnOut !== e.out || longHeld !== e.held ||
                        anyChange !== |(e.rise | e.fall)) begin
                        miscompares++;
                        $display("[TB] FAIL %s: got cyc=%0d rise=%b fall=%b long=%b out=%b held=%b any=%b, want cyc=%0d rise=%b fall=%b long=%b out=%b held=%b any=%b",
                                 e.name, cyc, risePulse, fallPulse, longPulse, btnOut, longHeld,
                                 anyChange, e.cyc, e.rise, e.fall, e.lng, e.out, e.held,
                                 |(e.rise | e.fall));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int t;
        int t2;
        event_t e;
        rst      = 1'b1;
        btnIn    = 2'b00;
        toggleEn = 2'b00;
        waitCyc(3);
        checkOutput("reset_idle", 2'b00, 2'b00);

        // Both channels pressed as reset releases, held into a long press.
        rst = 1'b0;
        applyStimulus(2'b11, t);
        pushExpect("por_rise", t + 8, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
        pushExpect("por_long", t + 18, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
        waitCyc(22);
        #2 rst = 1'b1;
        #1 checkOutput("reset_async", 2'b00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        t   = cyc;
        pushExpect("rerelease_rise", t + 8, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00);
        waitCyc(9);
        applyStimulus(2'b00, t2);
        pushExpect("both_fall", t2 + 8, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
        waitCyc(12);

        // Clean press and release on channel 0.
        applyStimulus(2'b01, t);
        pushExpect("clean_rise", t + 8, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        waitCyc(9);
        applyStimulus(2'b00, t);
        pushExpect("clean_fall", t + 8, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        waitCyc(12);

        // Bounce: high 3, low 1, then held; accepted from the last rise.
        applyStimulus(2'b01, t);
        waitCyc(3);
        applyStimulus(2'b00, t);
        waitCyc(1);
        applyStimulus(2'b01, t);
        pushExpect("bounce_rise", t + 8, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
        waitCyc(9);
        applyStimulus(2'b00, t);
        pushExpect("bounce_fall", t + 8, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        waitCyc(12);

        // Four-cycle glitch on channel 1 must never surface.
        applyStimulus(2'b10, t);
        waitCyc(4);
        applyStimulus(2'b00, t);
        waitCyc(12);
        checkOutput("glitch_out", 2'b00, 2'b00);

        // Six-cycle pulse is the shortest one accepted with limit 4.
        applyStimulus(2'b10, t);
        pushExpect("min_rise", t + 8, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        waitCyc(6);
        applyStimulus(2'b00, t2);
        pushExpect("min_fall", t2 + 8, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        waitCyc(12);

        // Reset clears toggle state before the toggle checks.
        rst = 1'b1;
        waitCyc(2);
        rst = 1'b0;
        waitCyc(2);

        // Toggle mode on channel 0: output flips 1,0,1 on each press.
        toggleEn = 2'b01;
        #1 checkOutput("toggle_enable", 2'b00, 2'b00);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [1:0] expOut;
            expOut = (k % 2 == 0) ? 2'b01 : 2'b00;
            applyStimulus(2'b01, t);
            pushExpect("toggle_rise", t + 8, 2'b01, 2'b00, 2'b00, expOut, 2'b00);
            waitCyc(9);
            applyStimulus(2'b00, t);
            pushExpect("toggle_fall", t + 8, 2'b00, 2'b01, 2'b00, expOut, 2'b00);
            waitCyc(12);
        end
        toggleEn = 2'b00;
        #1 checkOutput("toggle_off_level", 2'b00, 2'b00);
        toggleEn = 2'b01;
        #1 checkOutput("toggle_back_on", 2'b01, 2'b00);
        toggleEn = 2'b00;
        @(negedge clk);

        // Long press on channel 1, then a short press without long pulse.
        applyStimulus(2'b10, t);
        pushExpect("long_rise", t + 8, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        pushExpect("long_pulse", t + 18, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10);
        waitCyc(25);
        checkOutput("long_held", 2'b10, 2'b10);
        applyStimulus(2'b00, t2);
        pushExpect("long_fall", t2 + 8, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        waitCyc(12);
        applyStimulus(2'b10, t);
        pushExpect("short_rise", t + 8, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
        waitCyc(9);
        applyStimulus(2'b00, t);
        pushExpect("short_fall", t + 8, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        waitCyc(20);

        // Any expected event still queued never appeared.
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: got no event, want event at cyc=%0d", e.name, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Synchronises and debounces CHANNELS raw button/switch inputs.
- Per channel, provides a selectable level or toggle output, one-cycle press/release pulses, and long-press detection.
- Sits between the board I/O pins and the CPU control/step logic, replacing per-button debouncer instances.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- CNT_WIDTH, 20: width of each debounce counter.
- DEBOUNCE_LIMIT, 20'hFFFFF: stable-sample count required before accepting a change. Must be < 2^CNT_WIDTH; 0 is legal.
- LONG_WIDTH, 24: width of each hold counter.
- LONG_LIMIT, 24'hFFFFFF: cycles the clean signal must stay high to flag a long press. Must be >=1 and < 2^LONG_WIDTH.

Ports:
- clk  input  1  system clock; all state is on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  CHANNELS  raw asynchronous button inputs.
- toggle_en  input  CHANNELS  per-channel mode: 0 = level, 1 = toggle/latch.
- btn_out  output  CHANNELS  debounced level (mode 0) or latched toggle state (mode 1).
- rise_pulse  output  CHANNELS  one-cycle pulse on accepted 0->1 (press).
- fall_pulse  output  CHANNELS  one-cycle pulse on accepted 1->0 (release).
- long_pulse  output  CHANNELS  one-cycle pulse when a hold reaches LONG_LIMIT.
- long_held  output  CHANNELS  high while the hold counter is saturated at LONG_LIMIT.
- any_change  output  1  OR of all rise_pulse and fall_pulse bits, same cycle.

Behaviour:
- Reset (rst=1, asynchronous): every flop clears to 0 (sync stages, prev, cnt, clean, toggle_state, hold, all pulses). All outputs read 0 while rst=1.
- Synchroniser: two-flop chain per channel, sync1<=btn_in[i], sync2<=sync1. The debounce core uses only sync2.
- Debounce core, per channel, evaluated each edge:
  - If sync2 != prev: prev<=sync2, cnt<=0.
  - Else: if cnt<DEBOUNCE_LIMIT then cnt<=cnt+1 (saturating). If cnt==DEBOUNCE_LIMIT and clean!=prev then clean<=prev.
- Latency: a raw change first sampled into sync1 at edge E appears on clean at edge E+DEBOUNCE_LIMIT+3, provided btn_in stays constant throughout.
- Glitch rejection: any sync2 bounce restarts cnt at 0. A pulse shorter than DEBOUNCE_LIMIT+1 synchronised cycles never reaches clean.
- Edge pulses: registered on the same edge that clean changes.
  - rise_pulse[i]=1 for exactly one cycle when clean goes 0->1.
  - fall_pulse[i]=1 for exactly one cycle when clean goes 1->0.
  - Otherwise both are 0. They are never both high on one channel.
- Toggle state: toggle_state[i] inverts on the same edge that rise_pulse[i] is set. It is unaffected by falls.
- Output mux: btn_out[i] = toggle_en[i] ? toggle_state[i] : clean[i].
  - The mux is combinational from registers; toggle_en is static configuration.
  - Changing toggle_en mid-operation switches the output immediately and does not modify toggle_state.
- Hold counter, per channel:
  - While clean=1: hold increments, saturating at LONG_LIMIT.
  - While clean=0: hold<=0.
  - long_pulse=1 for exactly one cycle on the edge where hold becomes LONG_LIMIT.
  - long_held = (hold==LONG_LIMIT).
  - A release clears long_held on the same edge that fall_pulse is set. There is no long_pulse retrigger until a fresh press.
- Channels are fully independent. Simultaneous events on different channels all report in the same cycle. any_change is their OR.
- Reset release with btn_in already high: treated as a press. rise_pulse fires at E+DEBOUNCE_LIMIT+3 after the first post-reset edge.
- Reset mid-operation: in-progress counts and toggle state are discarded. No pulse is emitted on reset entry or exit.
- DEBOUNCE_LIMIT=0: a change is accepted on the edge after prev updates (clean at E+3).

Test Plan:
Bench configuration for all scenarios: CHANNELS=2, DEBOUNCE_LIMIT=4, LONG_LIMIT=10.
- Reset: assert rst mid-count with btn_in=2'b11 -> all outputs 0 immediately. After release, clean[1:0]=11 and rise_pulse=11 for one cycle at edge 7 after the first sampling edge.
- Clean press: btn_in[0] 0->1 held -> btn_out[0]=1 and rise_pulse[0]=1 at E+7, any_change=1 that cycle. Release -> fall_pulse[0]=1 at E'+7.
- Bounce: btn_in[0] high 3 cycles, low 1, high held -> no output during bounce. Accepted 7 edges after the last 0->1 sample. Exactly one rise_pulse.
- Glitch: btn_in[1] high for 4 cycles then low -> btn_out[1], rise_pulse[1] and fall_pulse[1] stay 0 throughout.
- Toggle: toggle_en=2'b01, three press/release cycles on ch0 -> btn_out[0] goes 1,0,1 at the rise edges. Setting toggle_en[0]=0 then shows the level immediately.
- Long press: hold ch1 -> long_pulse[1]=1 for one cycle 10 edges after rise_pulse[1], then long_held[1]=1 until the release edge. A short press (<10 cycles) yields no long_pulse.
